// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a little-endian byte stream into WIDTH-bit
// words, writes them from address 0 upward, and holds the core in reset until done.
module imem_loader #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              core_rst
);

   localparam int BYTES  = WIDTH / 8;
   localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
   logic              err_q, err_d;
   logic              core_rst_q, core_rst_d;
   logic              byte_ready_q, byte_ready_d;
   logic              mem_we_q, mem_we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              xfer_s;
   logic              last_word_s;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      byte_cnt_d  = byte_cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = err_q;
      core_rst_d  = core_rst_q;
      xfer_s      = (state_q == S_RECV) && byte_valid;
      // len_q >= 1 and addr only advances while addr+1 < len_q, so addr stays below DEPTH
      last_word_s = (({1'b0, mem_addr_q} + (ADDR_W + 1)'(1)) == len_q);

      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               if ((load_len != (ADDR_W + 1)'(0)) && (load_len <= DEPTH_L)) begin
                  len_d      = load_len;
                  err_d      = 1'b0;
                  byte_cnt_d = '0;
                  mem_addr_d = '0;
                  core_rst_d = 1'b1;
                  state_d    = S_RECV;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RECV: begin
            if (xfer_s) begin
               mem_wdata_d[8 * int'(byte_cnt_q) +: 8] = byte_data;
               if (byte_cnt_q == BCNT_LAST) begin
                  byte_cnt_d = '0;
                  state_d    = S_WRITE;
               end else begin
                  byte_cnt_d = byte_cnt_q + BCNT_W'(1);
               end
            end else begin
               state_d = S_RECV;
            end
         end
         S_WRITE: begin
            if (last_word_s) begin
               core_rst_d = 1'b0;
               state_d    = S_DONE;
            end else begin
               mem_addr_d = mem_addr_q + ADDR_W'(1);
               state_d    = S_RECV;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      byte_ready_d = (state_d == S_RECV);
      mem_we_d     = (state_d == S_WRITE);
      busy_d       = (state_d == S_RECV) || (state_d == S_WRITE);
      done_d       = (state_d == S_DONE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         byte_cnt_q   <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         err_q        <= 1'b0;
         core_rst_q   <= 1'b1;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         byte_cnt_q   <= byte_cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         err_q        <= err_d;
         core_rst_q   <= core_rst_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= mem_we_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign core_rst   = core_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed tests, a length table and randomized loads
// compared against a word-level model of the expected memory writes.
module tb_imem_loader;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic              clk;
   logic              rst;
   logic              load_start;
   logic [ADDR_W:0]   load_len;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic              core_rst;

   imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
      .done(done), .err(err), .core_rst(core_rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  data;
   } wr_t;

   typedef struct {
      logic [ADDR_W:0] len;
      logic            exp_err;
      logic            exp_busy;
      int              gap;
   } vec_t;

   wr_t         exp_q[$];
   logic [31:0] wbuf[DEPTH];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   logic        prev_we  = 1'b0;
   logic        model_core_rst = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Write monitor: every mem_we must match the head of the expected-write queue
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) begin
            check("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               wr_t e;
               e = exp_q.pop_front();
               check("we_addr", 64'(mem_addr), 64'(e.addr));
               check("we_data", 64'(mem_wdata), 64'(e.data));
            end
         end
         if (done) begin
            done_cnt++;
            check("done_after_last_we", 64'(prev_we), 64'd1);
            check("core_rst_with_done", 64'(core_rst), 64'd0);
         end
         prev_we = mem_we;
      end else begin
         prev_we = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
      check({tag, "_mem_we"},     64'(mem_we),     64'd0);
      check({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
      check({tag, "_mem_wdata"},  64'(mem_wdata),  64'd0);
      check({tag, "_busy"},       64'(busy),       64'd0);
      check({tag, "_done"},       64'(done),       64'd0);
      check({tag, "_err"},        64'(err),        64'd0);
      check({tag, "_core_rst"},   64'(core_rst),   64'd1);
   endtask

   task automatic do_start(input logic [ADDR_W:0] len);
      load_start = 1'b1;
      load_len   = len;
      tick();
      load_start = 1'b0;
      load_len   = '0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic rdy;
      int   t;
      byte_valid = 1'b1;
      byte_data  = b;
      t   = 0;
      rdy = 1'b0;
      while (!rdy && t <= 100) begin
         rdy = byte_ready;
         tick();
         t++;
      end
      if (!rdy) check("byte_accept_timeout", 64'(t), 64'd0);
      byte_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_done(input int start_cnt, input int bound);
      int t;
      t = 0;
      while (done_cnt == start_cnt && t < bound) begin
         tick();
         t++;
      end
      check("done_seen", 64'(done_cnt - start_cnt), 64'd1);
      repeat (3) tick();
      check("single_done", 64'(done_cnt - start_cnt), 64'd1);
   endtask

   // Model: word k goes to address k; its bytes are sent least-significant first
   task automatic feed_words(input int len, input int gap);
      int start_cnt;
      start_cnt = done_cnt;
      for (int k = 0; k < len; k++) exp_q.push_back({ADDR_W'(k), wbuf[k]});
      for (int k = 0; k < len; k++)
         for (int j = 0; j < WIDTH / 8; j++) send_byte(wbuf[k][8*j +: 8], gap);
      wait_done(start_cnt, 100);
      model_core_rst = 1'b0;
      check("all_writes_seen", 64'(exp_q.size()), 64'd0);
      check("busy_after_load", 64'(busy), 64'd0);
      check("core_rst_after_load", 64'(core_rst), 64'(model_core_rst));
      check("ready_after_load", 64'(byte_ready), 64'd0);
   endtask

   task automatic legal_start(input int len);
      do_start((ADDR_W + 1)'(len));
      model_core_rst = 1'b1;
      check("start_busy", 64'(busy), 64'd1);
      check("start_err", 64'(err), 64'd0);
      check("start_core_rst", 64'(core_rst), 64'(model_core_rst));
   endtask

   initial begin
      vec_t vecs[7];
      int   len, gap, start_cnt;

      vecs[0] = '{len: 7'd0,   exp_err: 1'b1, exp_busy: 1'b0, gap: 0};
      vecs[1] = '{len: 7'd65,  exp_err: 1'b1, exp_busy: 1'b0, gap: 0};
      vecs[2] = '{len: 7'd1,   exp_err: 1'b0, exp_busy: 1'b1, gap: 1};
      vecs[3] = '{len: 7'd127, exp_err: 1'b1, exp_busy: 1'b0, gap: 0};
      vecs[4] = '{len: 7'd3,   exp_err: 1'b0, exp_busy: 1'b1, gap: 0};
      vecs[5] = '{len: 7'd0,   exp_err: 1'b1, exp_busy: 1'b0, gap: 0};
      vecs[6] = '{len: 7'd2,   exp_err: 1'b0, exp_busy: 1'b1, gap: 2};

      rst = 1'b1; load_start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // T1 basic load and T2 same stream with 3-cycle gaps
      wbuf[0] = 32'h0050_0513;
      wbuf[1] = 32'h00B5_05B3;
      legal_start(2);
      feed_words(2, 0);
      legal_start(2);
      feed_words(2, 3);

      // Length table: illegal lengths set err and stay idle, legal ones run a full load
      for (int i = 0; i < 7; i++) begin
         do_start(vecs[i].len);
         if (vecs[i].exp_busy) model_core_rst = 1'b1;
         check("tbl_err", 64'(err), 64'(vecs[i].exp_err));
         check("tbl_busy", 64'(busy), 64'(vecs[i].exp_busy));
         check("tbl_core_rst", 64'(core_rst), 64'(model_core_rst));
         if (vecs[i].exp_busy) begin
            for (int k = 0; k < int'(vecs[i].len); k++) wbuf[k] = $urandom;
            feed_words(int'(vecs[i].len), vecs[i].gap);
         end else begin
            repeat (4) tick();
            check("tbl_idle_busy", 64'(busy), 64'd0);
         end
      end

      // T4 reset mid-load abandons the partial word
      legal_start(1);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      rst = 1'b1;
      tick();
      check_reset_outputs("midload_reset");
      rst = 1'b0;
      model_core_rst = 1'b1;
      tick();
      legal_start(1);
      start_cnt = done_cnt;
      exp_q.push_back({ADDR_W'(0), 32'h4433_2211});
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      wait_done(start_cnt, 50);
      check("t4_writes_seen", 64'(exp_q.size()), 64'd0);
      check("t4_core_rst", 64'(core_rst), 64'd0);

      // T5 full depth, word k = k
      for (int k = 0; k < DEPTH; k++) wbuf[k] = 32'(k);
      legal_start(DEPTH);
      feed_words(DEPTH, 0);

      // T6 load_start during RECV is ignored
      legal_start(1);
      wbuf[0] = 32'hCAFE_F00D;
      start_cnt = done_cnt;
      exp_q.push_back({ADDR_W'(0), wbuf[0]});
      send_byte(wbuf[0][7:0], 0);
      send_byte(wbuf[0][15:8], 0);
      do_start(7'd5);
      check("t6_busy_after_ignored_start", 64'(busy), 64'd1);
      send_byte(wbuf[0][23:16], 0);
      send_byte(wbuf[0][31:24], 0);
      wait_done(start_cnt, 50);
      check("t6_writes_seen", 64'(exp_q.size()), 64'd0);

      // Randomized loads, with an illegal start after each
      for (int it = 0; it < 6; it++) begin
         len = $urandom_range(1, 8);
         gap = $urandom_range(0, 2);
         for (int k = 0; k < len; k++) wbuf[k] = $urandom;
         legal_start(len);
         feed_words(len, gap);
         do_start((ADDR_W + 1)'($urandom_range(DEPTH + 1, 127)));
         check("rand_illegal_err", 64'(err), 64'd1);
         check("rand_illegal_busy", 64'(busy), 64'd0);
         check("rand_illegal_core_rst", 64'(core_rst), 64'(model_core_rst));
      end

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
